// File: rtl/dht_start_handshake.sv
// Start/handshake engine for DHT11/DHT22-class single-wire sensors: issues the host
// start pulse, then validates the sensor's response phases.
module dht_start_handshake #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int START_LOW_US    = 18000,
  parameter int RESP_US         = 80,
  parameter int TOL_US          = 10,
  parameter int RESP_TIMEOUT_US = 100,
  parameter int GUARD_US        = 1_000_000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       ok,
  output logic [1:0] err_code
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_N   = CNT_W'(GUARD_US);
  localparam logic [CNT_W-1:0] START_N   = CNT_W'(START_LOW_US);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(RESP_TIMEOUT_US);
  localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(RESP_US - TOL_US);
  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(RESP_US + TOL_US);
  localparam logic [CNT_W-1:0] OVER_N    = CNT_W'(RESP_US + TOL_US + 1);

  typedef enum logic [2:0] {
    S_GUARD,
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_PASS,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] us_q, us_d;
  logic             dq_meta_q, dq_meta_d;
  logic             dq_sync_q, dq_sync_d;
  logic             dq_prev_q, dq_prev_d;
  logic             dq_oe_q, dq_oe_d;
  logic             ok_q, ok_d;
  logic [1:0]       err_q, err_d;

  logic             tick;
  logic [CNT_W-1:0] cnt_next;
  logic             rise;
  logic             fall;
  logic             in_window;
  logic             over_window;

  // cnt_next is the completed-microsecond count including the current cycle, so a
  // phase of N us measured from state entry compares exactly against N.
  always_comb begin
    tick        = (pre_q == PRE_LAST);
    cnt_next    = us_q + CNT_W'(tick);
    rise        = dq_sync_q & ~dq_prev_q;
    fall        = ~dq_sync_q & dq_prev_q;
    in_window   = (cnt_next >= WIN_LO) && (cnt_next <= WIN_HI);
    over_window = (cnt_next >= OVER_N);
  end

  always_comb begin
    dq_meta_d = dq_in;
    dq_sync_d = dq_meta_q;
    dq_prev_d = dq_sync_q;
  end

  always_comb begin
    state_d = state_q;
    ok_d    = ok_q;
    err_d   = err_q;
    case (state_q)
      S_GUARD: begin
        if (cnt_next == GUARD_N) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_START_LOW;
          ok_d    = 1'b0;
          err_d   = 2'd0;
        end
      end
      S_START_LOW: begin
        if (cnt_next == START_N) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (!dq_sync_q) begin
          state_d = S_RESP_LOW;
        end else if (cnt_next == TIMEOUT_N) begin
          state_d = S_FAIL;
          ok_d    = 1'b0;
          err_d   = 2'd1;
        end
      end
      S_RESP_LOW: begin
        if (rise && in_window) begin
          state_d = S_RESP_HIGH;
        end else if (rise || over_window) begin
          state_d = S_FAIL;
          ok_d    = 1'b0;
          err_d   = 2'd2;
        end
      end
      S_RESP_HIGH: begin
        if (fall && in_window) begin
          state_d = S_PASS;
          ok_d    = 1'b1;
          err_d   = 2'd0;
        end else if (fall || over_window) begin
          state_d = S_FAIL;
          ok_d    = 1'b0;
          err_d   = 2'd3;
        end
      end
      S_PASS:  state_d = S_GUARD;
      S_FAIL:  state_d = S_GUARD;
      default: state_d = S_GUARD;
    endcase
  end

  // Timebase restarts on every state change so each state measures its own duration.
  always_comb begin
    pre_d = pre_q;
    us_d  = us_q;
    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = '0;
    end else if (tick) begin
      pre_d = '0;
      us_d  = cnt_next;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Registered so the bus driver is glitch-free and drops straight from reset.
  always_comb begin
    dq_oe_d = (state_d == S_START_LOW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_GUARD;
      pre_q     <= '0;
      us_q      <= '0;
      dq_meta_q <= 1'b1;
      dq_sync_q <= 1'b1;
      dq_prev_q <= 1'b1;
      dq_oe_q   <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      us_q      <= us_d;
      dq_meta_q <= dq_meta_d;
      dq_sync_q <= dq_sync_d;
      dq_prev_q <= dq_prev_d;
      dq_oe_q   <= dq_oe_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign dq_oe    = dq_oe_q;
  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_START_LOW) || (state_q == S_WAIT_RESP) ||
                    (state_q == S_RESP_LOW)  || (state_q == S_RESP_HIGH);
  assign done     = (state_q == S_PASS) || (state_q == S_FAIL);
  assign ok       = ok_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_dht_start_handshake.sv
// Randomised bench for dht_start_handshake: a sensor model answers each start
// request and the expected outcome is worked out from the phase durations alone.
module tb_dht_start_handshake;

  // Simulation timing: 2 MHz clock, so one microsecond is two cycles.
  localparam int CYC_PER_US = 2;
  localparam int START_CYC  = 50 * CYC_PER_US;
  localparam int TMO_CYC    = 100 * CYC_PER_US;
  localparam int GUARD_CYC  = 200 * CYC_PER_US;
  localparam int WIN_LO_US  = 70;
  localparam int WIN_HI_US  = 90;
  localparam int SYNC_LAT   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dq_in;
  logic       dq_oe;
  logic       ready;
  logic       busy;
  logic       done;
  logic       ok;
  logic [1:0] err_code;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  dht_start_handshake #(
    .CLK_FREQ_HZ     (2_000_000),
    .START_LOW_US    (50),
    .RESP_US         (80),
    .TOL_US          (10),
    .RESP_TIMEOUT_US (100),
    .GUARD_US        (200),
    .CNT_W           (21)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dq_in    (dq_in),
    .dq_oe    (dq_oe),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .ok       (ok),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Sensor waveform k cycles after the host releases the bus.
  function automatic logic sensorLevel(input int k, input int w, input int l, input int h,
                                       input bit noResp);
    if (noResp)          return 1'b1;
    if (k < w)           return 1'b1;
    if (k < w + l)       return 1'b0;
    if (k < w + l + h)   return 1'b1;
    if (k < w + l + h + 100) return 1'b0;
    return 1'b1;
  endfunction

  // Releases reset at a falling edge and expects a full guard interval before ready.
  task automatic applyStimulusReset(input string name);
    int k;
    int noisy;
    k = 0;
    noisy = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      k++;
      if (dq_oe || busy || done) noisy++;
      if (ready) break;
    end
    start = 1'b0;
    checkOutput($sformatf("%s.guardCycles", name), k, GUARD_CYC);
    checkOutput($sformatf("%s.quietOutputs", name), noisy, 0);
    checkOutput($sformatf("%s.ok", name), ok, 0);
    checkOutput($sformatf("%s.err", name), err_code, 0);
  endtask

  // Entered at a falling edge with ready=1; the start raised here lands in the
  // first ready cycle. Start is then toggled randomly while it must be ignored.
  task automatic applyStimulus(input string name, input int w, input int l, input int h,
                               input bit noResp);
    int accept, rel, firstOe, oeCount, doneCount, doneAt, busyCount, readyAt;
    int okAt, errAt, busyAtDone, okHeld, errHeld;
    int relExp, entry, expD, expOk, expErr;
    rel = -1; firstOe = -1; oeCount = 0; doneCount = 0; doneAt = -1;
    busyCount = 0; readyAt = -1; okAt = -1; errAt = -1; busyAtDone = -1;
    okHeld = -1; errHeld = -1;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accept = cyc;
    checkOutput($sformatf("%s.okCleared", name), ok, 0);
    checkOutput($sformatf("%s.errCleared", name), err_code, 0);

    for (int i = 0; i < 3000; i++) begin
      if (dq_oe) begin
        oeCount++;
        if (firstOe < 0) firstOe = cyc;
      end else if (firstOe >= 0 && rel < 0) begin
        rel = cyc;
      end
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        doneAt = cyc;
        okAt = ok;
        errAt = err_code;
        busyAtDone = busy;
      end
      if (ready) begin
        readyAt = cyc;
        okHeld = ok;
        errHeld = err_code;
        break;
      end
      dq_in = (rel >= 0) ? sensorLevel(cyc - rel, w, l, h, noResp) : 1'b1;
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    dq_in = 1'b1;

    // Reference outcome from phase lengths in whole microseconds.
    relExp = accept + START_CYC;
    expOk = 0;
    if (noResp) begin
      expD = relExp + TMO_CYC;
      expErr = 1;
    end else begin
      entry = relExp + w + SYNC_LAT;
      if (l / CYC_PER_US > WIN_HI_US) begin
        expD = entry + (WIN_HI_US + 1) * CYC_PER_US;
        expErr = 2;
      end else if (l / CYC_PER_US < WIN_LO_US) begin
        expD = entry + l;
        expErr = 2;
      end else begin
        entry = entry + l;
        if (h / CYC_PER_US > WIN_HI_US) begin
          expD = entry + (WIN_HI_US + 1) * CYC_PER_US;
          expErr = 3;
        end else begin
          expD = entry + h;
          expErr = (h / CYC_PER_US < WIN_LO_US) ? 3 : 0;
          expOk = (expErr == 0) ? 1 : 0;
        end
      end
    end

    checkOutput($sformatf("%s.oeStart", name), firstOe, accept);
    checkOutput($sformatf("%s.oeCycles", name), oeCount, START_CYC);
    checkOutput($sformatf("%s.release", name), rel, relExp);
    checkOutput($sformatf("%s.donePulses", name), doneCount, 1);
    checkOutput($sformatf("%s.doneAt", name), doneAt, expD);
    checkOutput($sformatf("%s.okAtDone", name), okAt, expOk);
    checkOutput($sformatf("%s.errAtDone", name), errAt, expErr);
    checkOutput($sformatf("%s.busyAtDone", name), busyAtDone, 0);
    checkOutput($sformatf("%s.busyCycles", name), busyCount, expD - accept);
    checkOutput($sformatf("%s.readyAt", name), readyAt, expD + 1 + GUARD_CYC);
    checkOutput($sformatf("%s.okHeld", name), okHeld, expOk);
    checkOutput($sformatf("%s.errHeld", name), errHeld, expErr);
  endtask

  initial begin
    int w, l, h;
    bit nr;
    rst = 1'b0;
    start = 1'b0;
    dq_in = 1'b1;
    #23;
    checkOutput("reset.dq_oe", dq_oe, 0);
    checkOutput("reset.ready", ready, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.ok", ok, 0);
    checkOutput("reset.err", err_code, 0);
    applyStimulusReset("reset");

    // Durations in cycles (2 per microsecond).
    applyStimulus("nominal", 60, 160, 160, 1'b0);
    applyStimulus("noResponse", 0, 0, 0, 1'b1);
    applyStimulus("low95", 40, 190, 160, 1'b0);
    applyStimulus("low69", 40, 138, 160, 1'b0);
    applyStimulus("low70", 40, 140, 160, 1'b0);
    applyStimulus("low90", 40, 180, 160, 1'b0);
    applyStimulus("high60", 40, 160, 120, 1'b0);
    applyStimulus("high90", 40, 160, 180, 1'b0);
    applyStimulus("high91", 40, 160, 182, 1'b0);

    for (int n = 0; n < 12; n++) begin
      w = $urandom_range(0, 190);
      l = $urandom_range(120, 200);
      h = $urandom_range(120, 200);
      nr = ($urandom_range(0, 7) == 0);
      applyStimulus($sformatf("rand%0d", n), w, l, h, nr);
    end

    // Reset in the middle of the start pulse must release the bus without a clock.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midReset.inStartLow", dq_oe, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midReset.dq_oe", dq_oe, 0);
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.ready", ready, 0);
    checkOutput("midReset.ok", ok, 0);
    checkOutput("midReset.err", err_code, 0);
    applyStimulusReset("midReset");
    applyStimulus("afterReset", 60, 160, 160, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dht_start_handshake.md
Name: dht_start_handshake

Overview:
- Parametrised start/handshake engine for DHT11/DHT22-class single-wire sensors, successor to the fixed-timing start sequencer.
- Drives the open-drain bus low for the start pulse, then releases it.
- Measures the sensor's response low/high phases against tolerance windows and hands a clean "sensor ready, first data bit starts now" event to the bit receiver.
- Adds a microsecond prescaler, input synchroniser, timeouts, error codes and an inter-request guard interval.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; TICK_DIV = CLK_FREQ_HZ/1_000_000, must be >= 1.
- START_LOW_US, 18000, host start pulse low time in us (use 1000 for DHT22).
- RESP_US, 80, nominal duration of each sensor response phase (low, then high) in us.
- TOL_US, 10, allowed +/- deviation for each response phase, inclusive.
- RESP_TIMEOUT_US, 100, maximum wait after release for the sensor to pull low.
- GUARD_US, 1_000_000, minimum idle time after reset or after any completed request before a new start is accepted.
- CNT_W, 21, width of the us counter; must hold max(START_LOW_US, GUARD_US).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when ready=1.
- dq_in  input  1  raw bus level, asynchronous.
- dq_oe  output  1  1 = drive bus low; 0 = release (pull-up high).
- ready  output  1  idle and guard expired; a start is accepted this cycle.
- busy  output  1  request in progress.
- done  output  1  one-cycle pulse at end of request (success or error).
- ok  output  1  result of last request; valid from done, held until next accepted start.
- err_code  output  2  0 none, 1 no response, 2 response-low out of window, 3 response-high out of window; held like ok.

Behaviour:
- Reset (rst=0, async): dq_oe=0, ready=0, busy=0, done=0, ok=0, err_code=0, state=GUARD.
  - Synchroniser flops reset to 1; counters cleared.
  - Reset mid-request releases the bus immediately.
- dq_in passes through a 2-flop synchroniser (2-cycle latency). All edges and levels use the synchronised value. Rise = prev 0 and now 1; fall = prev 1 and now 0.
- us tick: prescaler counts 0..TICK_DIV-1 and ticks when it wraps. Prescaler and us counter clear on every state entry, so the count equals completed microseconds in the state.
- States:
  - GUARD: ready=0. After GUARD_US ticks, go to IDLE.
  - IDLE: ready=1. start=1 goes to START_LOW next cycle. In that same cycle ok and err_code clear and busy rises. start in any other state is ignored.
  - START_LOW: dq_oe=1. After START_LOW_US ticks (exactly START_LOW_US*TICK_DIV cycles), dq_oe=0 and go to WAIT_RESP.
  - WAIT_RESP: on synchronised level 0, go to RESP_LOW. If the count reaches RESP_TIMEOUT_US first, go to FAIL with err 1.
  - RESP_LOW:
    - On rise with count in [RESP_US-TOL_US, RESP_US+TOL_US], go to RESP_HIGH.
    - On rise with count below the window, FAIL err 2.
    - If the count reaches RESP_US+TOL_US+1 while still low, FAIL err 2 immediately.
  - RESP_HIGH: same rules on fall; failures use err 3. A pass goes to PASS.
  - PASS: done=1, ok=1, err_code=0 for one cycle, then GUARD.
  - FAIL: done=1, ok=0, err_code set for one cycle, then GUARD.
- busy is 1 from the cycle after start through the cycle before done. It is 0 in the done cycle.
- The done pulse on PASS coincides (+2-cycle sync latency) with the falling edge that starts the first data bit. The bit receiver arms on done&ok.
- dq_oe is never asserted outside START_LOW.

Test Plan:
- Sim parameters for all scenarios: CLK_FREQ_HZ=2_000_000, START_LOW_US=50, RESP_US=80, TOL_US=10, RESP_TIMEOUT_US=100, GUARD_US=200.
- Reset release, dq_in=1 -> ready=0 for 400 cycles, then 1; dq_oe, busy, done stay 0.
- Nominal: start pulse when ready; model pulls low 30us after release, low 80us, high 80us, then low -> dq_oe=1 for exactly 100 cycles; done one cycle with ok=1, err_code=0; ready returns 400 cycles after done.
- dq_in held 1 -> done at 100us after release, ok=0, err_code=1.
- Low phase 95us -> done when the low count hits 91us, before the rise, err_code=2. Separate run with low 69us -> done on the rise, err_code=2. Low exactly 70us and 90us -> pass.
- High phase 60us -> err_code=3. High exactly 90us -> ok=1.
- start during busy, during GUARD, and in the cycle ready rises -> only the last is accepted. rst=0 mid-START_LOW -> dq_oe=0 without a clock edge; after release, guard of 400 cycles again; ok and err_code are 0.
